// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: forwarding, load-use, redirect flush and multi-cycle stall control; PIPE_HAZARD_PERF_EN adds perf counters
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MC_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rs1_addr,
  input  logic [4:0]  ex_rs2_addr,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_reg_wr,
  input  logic        ex_is_load,
  input  logic        ex_redirect,
  input  logic        ex_mc_start,
  input  logic        mc_done,
  input  logic [4:0]  mem_rd_addr,
  input  logic        mem_reg_wr,
  input  logic [4:0]  wb_rd_addr,
  input  logic        wb_reg_wr,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        bubble_ex,
  output logic        flush_id,
  output logic [1:0]  fwd_rs1_sel,
  output logic [1:0]  fwd_rs2_sel,
  output logic        mc_busy,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_cycles,
  output logic [15:0] perf_mc_timeouts,
`endif
  output logic        mc_timeout
);
  localparam logic [1:0] RUN = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] MC_WAIT = 2'd2;
  logic [1:0] state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic in_run, in_flush, in_mc, load_use, redir, mc_go, lu, to_hit, mc_hold;
  function automatic logic [1:0] fwd(input logic [4:0] rs);
    return (mem_reg_wr && mem_rd_addr != 5'd0 && mem_rd_addr == rs) ? 2'b01 :
           (wb_reg_wr && wb_rd_addr != 5'd0 && wb_rd_addr == rs) ? 2'b10 : 2'b00;
  endfunction
  // hazard decode, output enables and next-state selection
  always_comb begin
    in_run = state == RUN;
    in_flush = state == FLUSH;
    in_mc = state == MC_WAIT;
    load_use = ex_is_load & ex_reg_wr & (ex_rd_addr != 5'd0) &
               ((id_uses_rs1 & (id_rs1_addr == ex_rd_addr)) | (id_uses_rs2 & (id_rs2_addr == ex_rd_addr)));
    redir = in_run & ex_redirect;
    mc_go = in_run & ~ex_redirect & ex_mc_start;
    lu = in_run & ~ex_redirect & ~ex_mc_start & load_use;
    to_hit = in_mc & ~mc_done & (cnt == 8'(MC_TIMEOUT - 1));
    mc_hold = in_mc & ~mc_done & ~to_hit;
    stall_if = ~rst & (mc_go | mc_hold | lu);
    stall_id = stall_if;
    stall_ex = ~rst & (mc_go | mc_hold);
    mc_busy = stall_ex;
    flush_id = ~rst & (redir | in_flush);
    bubble_ex = ~rst & (redir | in_flush | lu);
    fwd_rs1_sel = rst ? 2'b00 : fwd(ex_rs1_addr);
    fwd_rs2_sel = rst ? 2'b00 : fwd(ex_rs2_addr);
    state_nx = (redir && FLUSH_CYCLES > 1) ? FLUSH :
               mc_go ? MC_WAIT :
               (in_flush && cnt != 8'd1) ? FLUSH :
               mc_hold ? MC_WAIT : RUN;
    cnt_nx = redir ? 8'(FLUSH_CYCLES - 1) :
             in_flush ? cnt - 8'd1 :
             mc_hold ? cnt + 8'd1 : 8'd0;
  end
  // state, counter and the registered timeout pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt <= 8'd0;
      mc_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      mc_timeout <= to_hit;
    end
  end
`ifdef PIPE_HAZARD_PERF_EN
  // saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= 32'd0;
      perf_flush_cycles <= 32'd0;
      perf_mc_timeouts <= 16'd0;
    end else begin
      perf_stall_cycles <= perf_stall_cycles + {31'd0, stall_if & ~&perf_stall_cycles};
      perf_flush_cycles <= perf_flush_cycles + {31'd0, flush_id & ~&perf_flush_cycles};
      perf_mc_timeouts <= perf_mc_timeouts + {15'd0, mc_timeout & ~&perf_mc_timeouts};
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench with FLUSH_CYCLES=3, MC_TIMEOUT=8
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, mem_rd_addr, wb_rd_addr;
  logic id_uses_rs1, id_uses_rs2, ex_reg_wr, ex_is_load, ex_redirect, ex_mc_start, mc_done, mem_reg_wr, wb_reg_wr;
  logic stall_if, stall_id, stall_ex, bubble_ex, flush_id, mc_busy, mc_timeout;
  logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flush_cycles;
  logic [15:0] perf_mc_timeouts;
`endif
  int checks = 0, errors = 0;
  logic [6:0] ctl;
  localparam logic [6:0] IDLE = 7'b0000000;
  localparam logic [6:0] LU = 7'b1101000;
  localparam logic [6:0] FL = 7'b0001100;
  localparam logic [6:0] MC = 7'b1110010;
  localparam logic [6:0] TO = 7'b0000001;
  always #5 clk = ~clk;
  assign ctl = {stall_if, stall_id, stall_ex, bubble_ex, flush_id, mc_busy, mc_timeout};
  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .MC_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_reg_wr(ex_reg_wr), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .ex_mc_start(ex_mc_start), .mc_done(mc_done),
    .mem_rd_addr(mem_rd_addr), .mem_reg_wr(mem_reg_wr),
    .wb_rd_addr(wb_rd_addr), .wb_reg_wr(wb_reg_wr),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .bubble_ex(bubble_ex), .flush_id(flush_id),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel), .mc_busy(mc_busy),
`ifdef PIPE_HAZARD_PERF_EN
    .perf_stall_cycles(perf_stall_cycles), .perf_flush_cycles(perf_flush_cycles),
    .perf_mc_timeouts(perf_mc_timeouts),
`endif
    .mc_timeout(mc_timeout)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear;
    {id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, mem_rd_addr, wb_rd_addr} = '0;
    {id_uses_rs1, id_uses_rs2, ex_reg_wr, ex_is_load, ex_redirect, ex_mc_start, mc_done, mem_reg_wr, wb_reg_wr} = '0;
  endtask
  initial begin
    clear();
    ex_redirect = 1'b1;
    ex_mc_start = 1'b1;
    mem_reg_wr = 1'b1; mem_rd_addr = 5'd3; ex_rs1_addr = 5'd3; ex_rs2_addr = 5'd3;
    #12;
    chk("reset_ctl", 32'(ctl), 32'(IDLE));
    chk("reset_fwd", 32'({fwd_rs1_sel, fwd_rs2_sel}), 32'd0);
    @(posedge clk); #1; rst = 1'b0; clear();
    tick();
    mem_reg_wr = 1'b1; mem_rd_addr = 5'd5; wb_reg_wr = 1'b1; wb_rd_addr = 5'd5; ex_rs1_addr = 5'd5; #1;
    chk("fwd_mem_prio", 32'(fwd_rs1_sel), 32'b01);
    mem_rd_addr = 5'd0; #1;
    chk("fwd_wb", 32'(fwd_rs1_sel), 32'b10);
    chk("fwd_rs2_x0", 32'(fwd_rs2_sel), 32'b00);
    mem_rd_addr = 5'd5; mem_reg_wr = 1'b0; ex_rs2_addr = 5'd5; #1;
    chk("fwd_mem_nowr", 32'(fwd_rs2_sel), 32'b10);
    wb_reg_wr = 1'b0; #1;
    chk("fwd_none", 32'(fwd_rs2_sel), 32'b00);
    clear();
    ex_is_load = 1'b1; ex_reg_wr = 1'b1; ex_rd_addr = 5'd7; id_uses_rs2 = 1'b1; id_rs2_addr = 5'd7; #1;
    chk("loaduse_hit", 32'(ctl), 32'(LU));
    tick(); clear(); #1;
    chk("loaduse_after", 32'(ctl), 32'(IDLE));
    ex_is_load = 1'b1; ex_reg_wr = 1'b1; ex_rd_addr = 5'd0; id_uses_rs2 = 1'b1; id_rs2_addr = 5'd0; #1;
    chk("loaduse_x0", 32'(ctl), 32'(IDLE));
    clear();
    ex_redirect = 1'b1; #1;
    chk("redir_n", 32'(ctl), 32'(FL));
    tick(); #1;
    ex_mc_start = 1'b1; #1;
    chk("redir_n1", 32'(ctl), 32'(FL));
    tick(); clear(); #1;
    chk("redir_n2", 32'(ctl), 32'(FL));
    tick();
    chk("redir_end", 32'(ctl), 32'(IDLE));
    ex_mc_start = 1'b1; #1;
    chk("mc_n", 32'(ctl), 32'(MC));
    tick(); ex_mc_start = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("mc_n%0d", i), 32'(ctl), 32'(MC));
      tick();
    end
    mc_done = 1'b1; #1;
    chk("mc_done", 32'(ctl), 32'(IDLE));
    tick(); mc_done = 1'b0; #1;
    chk("mc_after", 32'(ctl), 32'(IDLE));
    ex_redirect = 1'b1; ex_mc_start = 1'b1; #1;
    chk("redir_mc_n", 32'(ctl), 32'(FL));
    tick(); clear(); #1;
    chk("redir_mc_n1", 32'(ctl), 32'(FL));
    tick();
    chk("redir_mc_n2", 32'(ctl), 32'(FL));
    tick();
    chk("redir_mc_end", 32'(ctl), 32'(IDLE));
    ex_mc_start = 1'b1; #1;
    chk("to_start", 32'(ctl), 32'(MC));
    tick(); ex_mc_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("to_wait%0d", i), 32'(ctl), 32'(MC));
      tick();
    end
    chk("to_release", 32'(ctl), 32'(IDLE));
    tick();
    chk("to_pulse", 32'(ctl), 32'(TO));
    tick();
    chk("to_pulse_end", 32'(ctl), 32'(IDLE));
`ifdef PIPE_HAZARD_PERF_EN
    chk("perf_timeouts", 32'(perf_mc_timeouts), 32'd1);
`endif
    ex_mc_start = 1'b1; #1;
    tick(); ex_mc_start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    mc_done = 1'b1; #1;
    chk("done_vs_to", 32'(ctl), 32'(IDLE));
    tick(); mc_done = 1'b0; #1;
    chk("done_vs_to_nopulse", 32'(ctl), 32'(IDLE));
    ex_mc_start = 1'b1; #1;
    tick(); ex_mc_start = 1'b0;
    tick();
    chk("rst_pre", 32'(ctl), 32'(MC));
    #2; rst = 1'b1; #1;
    chk("rst_async", 32'(ctl), 32'(IDLE));
    #1; rst = 1'b0;
    tick();
    chk("rst_run", 32'(ctl), 32'(IDLE));
    tick();
    chk("rst_run2", 32'(ctl), 32'(IDLE));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
